uart_rx: RTL and testbench



---
 rtl/uart_rx_if.sv | 25 ++
 rtl/uart_rx.sv | 173 +++++++++++++++++
 tb/tb_uart_rx.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Serial receiver bus: serial line and frame configuration in, received byte and
// per-frame status pulses out. The master side drives the line, the slave is the receiver.
interface uart_rx_if #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
);
    logic                  RX_IN;
    logic [PRESCALE_W-1:0] Prescale;
    logic                  Par_En;
    logic                  Par_Typ;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_Valid;
    logic                  PAR_Err;
    logic                  STP_Err;

    modport master (
        output RX_IN, Prescale, Par_En, Par_Typ,
        input  P_DATA, Data_Valid, PAR_Err, STP_Err
    );

    modport slave (
        input  RX_IN, Prescale, Par_En, Par_Typ,
        output P_DATA, Data_Valid, PAR_Err, STP_Err
    );
endinterface

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start bit, DATA_WIDTH data bits LSB first, optional
// parity, one stop bit. Each bit is the 3-sample majority around mid-bit; the frame
// result (byte + Data_Valid, or error pulses) is issued at the middle of the stop bit.
module uart_rx #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic      clk,
    input  logic      rst_n,
    uart_rx_if.slave  rx_if
);
    localparam int BIT_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                state_reg;
    state_t                state_next;
    logic [PRESCALE_W-1:0] edge_cnt_reg;
    logic [BIT_CNT_W-1:0]  bit_cnt_reg;
    logic [PRESCALE_W-1:0] prescale_reg;
    logic                  par_en_reg;
    logic                  par_typ_reg;
    logic [2:0]            samples_reg;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic                  par_pend_reg;
    logic [DATA_WIDTH-1:0] p_data_reg;
    logic                  data_valid_reg;
    logic                  par_err_reg;
    logic                  stp_err_reg;

    logic                  rx;
    logic                  start_detect;
    logic [PRESCALE_W-1:0] half_p;
    logic [2:0]            sample_hit;
    logic                  sample_edge;
    logic                  decision_edge;
    logic                  bit_end;
    logic                  last_data_bit;
    logic                  majority;
    logic                  exp_parity;

    assign rx           = rx_if.RX_IN;
    assign start_detect = (state_reg == IDLE) && !rx;
    assign half_p       = {1'b0, prescale_reg[PRESCALE_W-1:1]};

    // Sample points sit at half_p-1, half_p and half_p+1 within each bit.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_sample
            assign sample_hit[gi] = (edge_cnt_reg == half_p + PRESCALE_W'(gi) - PRESCALE_W'(1));
        end
    endgenerate

    assign sample_edge   = (state_reg != IDLE) && (|sample_hit);
    assign decision_edge = (state_reg != IDLE) && (edge_cnt_reg == half_p + PRESCALE_W'(2));
    assign bit_end       = (edge_cnt_reg == prescale_reg - PRESCALE_W'(1));
    assign last_data_bit = (bit_cnt_reg == BIT_CNT_W'(DATA_WIDTH - 1));
    assign majority      = (samples_reg[0] & samples_reg[1]) |
                           (samples_reg[0] & samples_reg[2]) |
                           (samples_reg[1] & samples_reg[2]);
    assign exp_parity    = par_typ_reg ? ~^shift_reg : ^shift_reg;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; a start-bit glitch wins over the bit boundary when both coincide.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (!rx) state_next = START;
            end
            START: begin
                if (decision_edge && majority) state_next = IDLE;
                else if (bit_end)              state_next = DATA;
            end
            DATA: begin
                if (bit_end && last_data_bit) state_next = par_en_reg ? PARITY : STOP;
            end
            PARITY: begin
                if (bit_end) state_next = STOP;
            end
            STOP: begin
                if (decision_edge) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Edge and bit counters; the detection cycle itself is edge 0, so counting resumes at 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
        end else if (state_reg == IDLE) begin
            edge_cnt_reg <= start_detect ? PRESCALE_W'(1) : '0;
            bit_cnt_reg  <= '0;
        end else begin
            if (state_next == IDLE || bit_end) edge_cnt_reg <= '0;
            else                               edge_cnt_reg <= edge_cnt_reg + PRESCALE_W'(1);
            if (state_reg == DATA && bit_end) begin
                bit_cnt_reg <= (state_next == DATA) ? bit_cnt_reg + BIT_CNT_W'(1) : '0;
            end
        end
    end

    // Frame configuration capture, mid-bit sampling, data shift and parity check.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescale_reg <= '0;
            par_en_reg   <= 1'b0;
            par_typ_reg  <= 1'b0;
            samples_reg  <= '0;
            shift_reg    <= '0;
            par_pend_reg <= 1'b0;
        end else begin
            if (start_detect) begin
                prescale_reg <= rx_if.Prescale;
                par_en_reg   <= rx_if.Par_En;
                par_typ_reg  <= rx_if.Par_Typ;
                par_pend_reg <= 1'b0;
            end
            if (sample_edge) begin
                samples_reg <= {samples_reg[1:0], rx};
            end
            if (state_reg == DATA && decision_edge) begin
                shift_reg <= {majority, shift_reg[DATA_WIDTH-1:1]};
            end
            if (state_reg == PARITY && decision_edge) begin
                par_pend_reg <= (majority != exp_parity);
            end
        end
    end

    // Registered frame result, issued for one clock at the stop-bit decision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_data_reg     <= '0;
            data_valid_reg <= 1'b0;
            par_err_reg    <= 1'b0;
            stp_err_reg    <= 1'b0;
        end else begin
            data_valid_reg <= 1'b0;
            par_err_reg    <= 1'b0;
            stp_err_reg    <= 1'b0;
            if (state_reg == STOP && decision_edge) begin
                stp_err_reg <= !majority;
                par_err_reg <= par_pend_reg;
                if (majority && !par_pend_reg) begin
                    p_data_reg     <= shift_reg;
                    data_valid_reg <= 1'b1;
                end
            end
        end
    end

    assign rx_if.P_DATA     = p_data_reg;
    assign rx_if.Data_Valid = data_valid_reg;
    assign rx_if.PAR_Err    = par_err_reg;
    assign rx_if.STP_Err    = stp_err_reg;
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: frames are driven bit by bit, the expected frame result is queued
// when the frame is sent, and output pulses are collected and compared in order.
module tb_uart_rx;
    localparam int BUDGET = 1000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_rx_if #(.DATA_WIDTH(8), .PRESCALE_W(6)) bus ();

    uart_rx #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rx_if (bus.slave)
    );

    typedef struct packed {
        logic [7:0]  data;
        logic        dv;
        logic        pe;
        logic        se;
        logic [31:0] cyc;
    } ev_t;

    ev_t         exp_q[$];
    ev_t         obs_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] cyc = '0;
    logic [7:0]  model_pdata = 8'h00;

    always @(posedge clk) cyc <= cyc + 32'd1;

    // Collect every output pulse with the clock count at which it appeared.
    always @(negedge clk) begin
        if (rst_n && (bus.Data_Valid || bus.PAR_Err || bus.STP_Err))
            obs_q.push_back({bus.P_DATA, bus.Data_Valid, bus.PAR_Err, bus.STP_Err, cyc});
    end

    // Drive one frame starting at the current negedge and queue its expected result.
    // Result appears (9 + Par_En)*P + P/2 + 2 clocks after the start bit's edge 0.
    task automatic send_frame(input logic [7:0] d, input logic pe, input logic pt,
                              input logic pbit, input logic sbit, input int p);
        logic exp_par, perr, serr;
        int   lat;
        exp_par = pt ? ~^d : ^d;
        perr    = pe && (pbit !== exp_par);
        serr    = !sbit;
        if (!perr && !serr) model_pdata = d;
        lat = (9 + int'(pe)) * p + p / 2 + 2;
        exp_q.push_back({model_pdata, !perr && !serr, perr, serr, cyc + 32'(lat) + 32'd1});
        bus.Prescale = 6'(p);
        bus.Par_En   = pe;
        bus.Par_Typ  = pt;
        bus.RX_IN    = 1'b0;
        repeat (p) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.RX_IN = d[i];
            repeat (p) @(negedge clk);
        end
        if (pe) begin
            bus.RX_IN = pbit;
            repeat (p) @(negedge clk);
        end
        bus.RX_IN = sbit;
        repeat (p) @(negedge clk);
        bus.RX_IN = 1'b1;
    endtask

    task automatic test_reset();
        bus.RX_IN = 1'b1; bus.Prescale = 6'd8; bus.Par_En = 1'b0; bus.Par_Typ = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bus.P_DATA, bus.Data_Valid, bus.PAR_Err, bus.STP_Err} !== 11'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got P_DATA=%h DV=%b PE=%b SE=%b, want all 0",
                     bus.P_DATA, bus.Data_Valid, bus.PAR_Err, bus.STP_Err);
        end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        n_checks++;
        if ({bus.P_DATA, bus.Data_Valid, bus.PAR_Err, bus.STP_Err} !== 11'h0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got P_DATA=%h DV=%b PE=%b SE=%b, want all 0",
                     bus.P_DATA, bus.Data_Valid, bus.PAR_Err, bus.STP_Err);
        end
        $display("test_reset done");
    endtask

    task automatic test_parity();
        ev_t e, o;
        send_frame(8'hA5, 1'b1, 1'b1, 1'b1, 1'b1, 8);  // odd parity, good
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 8);  // even parity, good
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 8);  // even parity, bad bit
        while (exp_q.size() > 0) begin
            for (int w = 0; w < BUDGET && obs_q.size() == 0; w++) @(negedge clk);
            n_checks++;
            if (obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL parity_timeout: got no pulse, want %0d more", exp_q.size());
                exp_q.delete();
            end else begin
                e = exp_q.pop_front(); o = obs_q.pop_front();
                if ({o.data, o.dv, o.pe, o.se} !== {e.data, e.dv, e.pe, e.se}) begin
                    n_fail++;
                    $display("FAIL parity_result: got P_DATA=%h DV=%b PE=%b SE=%b, want P_DATA=%h DV=%b PE=%b SE=%b",
                             o.data, o.dv, o.pe, o.se, e.data, e.dv, e.pe, e.se);
                end
                n_checks++;
                if (o.cyc !== e.cyc) begin
                    n_fail++;
                    $display("FAIL parity_latency: got cycle %0d, want %0d", o.cyc, e.cyc);
                end
                $display("parity frame P_DATA=%h DV=%b PE=%b SE=%b @%0d", o.data, o.dv, o.pe, o.se, o.cyc);
            end
        end
        repeat (40) @(negedge clk);
        n_checks++;
        if (obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL parity_extra: got %0d extra pulses, want 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_no_parity();
        ev_t e, o;
        send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 8);  // good
        send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 8);  // stop bit low
        while (exp_q.size() > 0) begin
            for (int w = 0; w < BUDGET && obs_q.size() == 0; w++) @(negedge clk);
            n_checks++;
            if (obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL nopar_timeout: got no pulse, want %0d more", exp_q.size());
                exp_q.delete();
            end else begin
                e = exp_q.pop_front(); o = obs_q.pop_front();
                if ({o.data, o.dv, o.pe, o.se} !== {e.data, e.dv, e.pe, e.se}) begin
                    n_fail++;
                    $display("FAIL nopar_result: got P_DATA=%h DV=%b PE=%b SE=%b, want P_DATA=%h DV=%b PE=%b SE=%b",
                             o.data, o.dv, o.pe, o.se, e.data, e.dv, e.pe, e.se);
                end
                n_checks++;
                if (o.cyc !== e.cyc) begin
                    n_fail++;
                    $display("FAIL nopar_latency: got cycle %0d, want %0d", o.cyc, e.cyc);
                end
                $display("no-parity frame P_DATA=%h DV=%b PE=%b SE=%b @%0d", o.data, o.dv, o.pe, o.se, o.cyc);
            end
        end
        repeat (40) @(negedge clk);
        n_checks++;
        if (obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL nopar_extra: got %0d extra pulses, want 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_glitch();
        ev_t e, o;
        bus.Prescale = 6'd8; bus.Par_En = 1'b0;
        bus.RX_IN = 1'b0;
        repeat (3) @(negedge clk);
        bus.RX_IN = 1'b1;
        repeat (30) @(negedge clk);
        n_checks++;
        if (obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL glitch_pulse: got %0d pulses, want 0", obs_q.size());
            obs_q.delete();
        end
        $display("glitch rejected check done");
        send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 8);
        while (exp_q.size() > 0) begin
            for (int w = 0; w < BUDGET && obs_q.size() == 0; w++) @(negedge clk);
            n_checks++;
            if (obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL glitch_timeout: got no pulse, want %0d more", exp_q.size());
                exp_q.delete();
            end else begin
                e = exp_q.pop_front(); o = obs_q.pop_front();
                if ({o.data, o.dv, o.pe, o.se, o.cyc} !== {e.data, e.dv, e.pe, e.se, e.cyc}) begin
                    n_fail++;
                    $display("FAIL glitch_followup: got P_DATA=%h DV=%b PE=%b SE=%b @%0d, want P_DATA=%h DV=%b PE=%b SE=%b @%0d",
                             o.data, o.dv, o.pe, o.se, o.cyc, e.data, e.dv, e.pe, e.se, e.cyc);
                end
                $display("post-glitch frame P_DATA=%h DV=%b @%0d", o.data, o.dv, o.cyc);
            end
        end
        repeat (10) @(negedge clk);
        n_checks++;
        if (obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL glitch_extra: got %0d extra pulses, want 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_back_to_back(input int p);
        ev_t e, o;
        logic [7:0] d;
        int mode, nbad;
        nbad = 0;
        for (int k = 0; k < 100; k++) begin
            d    = 8'($urandom_range(0, 255));
            mode = int'($urandom_range(0, 2));
            if (mode == 0)      send_frame(d, 1'b0, 1'b0, 1'b0, 1'b1, p);
            else if (mode == 1) send_frame(d, 1'b1, 1'b0, ^d, 1'b1, p);
            else                send_frame(d, 1'b1, 1'b1, ~^d, 1'b1, p);
        end
        while (exp_q.size() > 0) begin
            for (int w = 0; w < BUDGET && obs_q.size() == 0; w++) @(negedge clk);
            n_checks++;
            if (obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL b2b_timeout P=%0d: got no pulse, want %0d more", p, exp_q.size());
                exp_q.delete();
            end else begin
                e = exp_q.pop_front(); o = obs_q.pop_front();
                if ({o.data, o.dv, o.pe, o.se, o.cyc} !== {e.data, e.dv, e.pe, e.se, e.cyc}) begin
                    n_fail++; nbad++;
                    $display("FAIL b2b_frame P=%0d: got P_DATA=%h DV=%b PE=%b SE=%b @%0d, want P_DATA=%h DV=%b PE=%b SE=%b @%0d",
                             p, o.data, o.dv, o.pe, o.se, o.cyc, e.data, e.dv, e.pe, e.se, e.cyc);
                end
            end
        end
        repeat (10) @(negedge clk);
        n_checks++;
        if (obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_extra P=%0d: got %0d extra pulses, want 0", p, obs_q.size());
            obs_q.delete();
        end
        $display("back-to-back P=%0d: 100 frames, %0d bad", p, nbad);
    endtask

    task automatic test_reset_mid_frame();
        ev_t e, o;
        bus.Prescale = 6'd8; bus.Par_En = 1'b0;
        bus.RX_IN = 1'b0;
        repeat (8) @(negedge clk);
        bus.RX_IN = 1'b1;
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.P_DATA, bus.Data_Valid, bus.PAR_Err, bus.STP_Err} !== 11'h0) begin
            n_fail++;
            $display("FAIL midframe_reset: got P_DATA=%h DV=%b PE=%b SE=%b, want all 0",
                     bus.P_DATA, bus.Data_Valid, bus.PAR_Err, bus.STP_Err);
        end
        model_pdata = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        send_frame(8'hF0, 1'b0, 1'b0, 1'b0, 1'b1, 8);
        while (exp_q.size() > 0) begin
            for (int w = 0; w < BUDGET && obs_q.size() == 0; w++) @(negedge clk);
            n_checks++;
            if (obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL midframe_timeout: got no pulse, want %0d more", exp_q.size());
                exp_q.delete();
            end else begin
                e = exp_q.pop_front(); o = obs_q.pop_front();
                if ({o.data, o.dv, o.pe, o.se, o.cyc} !== {e.data, e.dv, e.pe, e.se, e.cyc}) begin
                    n_fail++;
                    $display("FAIL midframe_followup: got P_DATA=%h DV=%b PE=%b SE=%b @%0d, want P_DATA=%h DV=%b PE=%b SE=%b @%0d",
                             o.data, o.dv, o.pe, o.se, o.cyc, e.data, e.dv, e.pe, e.se, e.cyc);
                end
                $display("post-reset frame P_DATA=%h DV=%b @%0d", o.data, o.dv, o.cyc);
            end
        end
        repeat (10) @(negedge clk);
        n_checks++;
        if (obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL midframe_extra: got %0d extra pulses, want 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    initial begin
        test_reset();
        test_parity();
        test_no_parity();
        test_glitch();
        test_reset_mid_frame();
        test_back_to_back(8);
        test_back_to_back(16);
        test_back_to_back(32);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog");
    end
endmodule
